alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The clock SHALL be `clk`, input, 1 bit, single clock domain; all state updates on its rising edge.
REQ-002 The reset SHALL be `reset`, input, 1 bit; it is synchronous and active-high.
REQ-003 `alu_in_one` SHALL be an 8-bit input: operand A, two's complement.
REQ-004 `alu_in_two` SHALL be an 8-bit input: operand B; it is ignored for shift operations.
REQ-005 `c12` SHALL be a 1-bit input: opcode bit 0.
REQ-006 `c13` SHALL be a 1-bit input: opcode bit 1.
REQ-007 `alu_result` SHALL be an 8-bit registered output: the operation result.
REQ-008 `alu_flags` SHALL be a 4-bit registered output: [3]=C carry, [2]=O overflow, [1]=N negative, [0]=Z zero.

Function
REQ-009 The opcode SHALL be {c13,c12}: 00 SHIFTL, 01 ADD, 10 SHIFTR, 11 SUB.
REQ-010 SHIFTL SHALL compute the result as {A[6:0],1'b0}, with C=A[7] and O=A[7]^A[6].
REQ-011 ADD SHALL compute the result as (A+B) mod 256, with C=carry-out of bit 7 and O=(A[7]==B[7])&&(R[7]!=A[7]).
REQ-012 SHIFTR SHALL be an arithmetic shift computing the result as {A[7],A[7:1]}, with C=A[0] and O=0.
REQ-013 SUB SHALL compute the result as A+~B+1 mod 256 (A-B), with C=carry-out of that sum (1 = no borrow) and O=(A[7]!=B[7])&&(R[7]!=A[7]).
REQ-014 For every opcode, N SHALL equal R[7] and Z SHALL be 1 iff R==8'h00.
REQ-015 Latency SHALL be one cycle: inputs sampled at edge k appear on alu_result/alu_flags after edge k, held until the next edge.
REQ-016 Outputs SHALL be updated on every non-reset edge; there is no enable and no handshake.
REQ-017 Outputs SHALL be glitch-free between edges (driven directly from flops).
REQ-018 Boundary: ADD 8'hFF+8'h01 SHALL give R=00, C=1, Z=1, O=0, N=0.
REQ-019 Boundary: SUB 8'h80-8'h01 SHALL give R=7F, O=1, C=1.
REQ-020 Boundary: SUB of equal operands SHALL give R=00, Z=1, C=1.
REQ-021 X/Z on the opcode SHALL NOT be given defined behaviour; synthesis treats the opcode decode as full-case.

Reset
REQ-022 When reset=1 at a rising edge, alu_result SHALL become 8'h00 and alu_flags SHALL become 4'b0000, regardless of the other inputs.
REQ-023 Reset asserted mid-stream SHALL discard the operation sampled on that edge.
REQ-024 The first edge after reset deassertion SHALL register the operation presented at that edge.

Structure
REQ-025 A shared package `alu_pkg` SHALL hold the opcode constants (OP_SHIFTL=2'b00, OP_ADD=2'b01, OP_SHIFTR=2'b10, OP_SUB=2'b11) and the flag bit-index constants (FLAG_C=3, FLAG_O=2, FLAG_N=1, FLAG_Z=0).
REQ-026 Sub-module `alu_adder8` SHALL provide an 8-bit ripple adder (a, b, cin -> sum, cout, ovf), shared by ADD (cin=0) and SUB (b inverted, cin=1).
REQ-027 The top level SHALL contain combinational opcode decode and a result/flag mux feeding one 12-bit register.

Verification
REQ-028 SHIFTL: reset, then A=8'h5A, B=8'h00, op=00 -> next cycle R=8'hB4, flags C=0 O=1 N=1 Z=0.
REQ-029 ADD: A=8'd120, B=8'd10, op=01 -> R=8'h82, C=0 O=1 N=1 Z=0; also A=FF, B=01 -> R=00, C=1 Z=1.
REQ-030 SHIFTR: A=8'h81, op=10 -> R=8'hC0, C=1 O=0 N=1 Z=0; A=8'h01 -> R=00, C=1 Z=1.
REQ-031 SUB: A=8'd20, B=8'd50, op=11 -> R=8'hE2, C=0 O=0 N=1 Z=0; A=80, B=01 -> R=7F, O=1 C=1.
REQ-032 Reset: assert reset for one edge while op=01, A=FF, B=01 -> R=00, flags=0000; the next edge with reset=0 -> R=00, flags C=1 Z=1.
REQ-033 Latency: change inputs every cycle for 4 back-to-back ops -> each result appears exactly one edge later, with none skipped.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and flag bit positions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    // Opcode is {c13, c12}
    typedef enum logic [1:0] {
        OP_SHIFTL = 2'b00,
        OP_ADD    = 2'b01,
        OP_SHIFTR = 2'b10,
        OP_SUB    = 2'b11
    } alu_op_e;

    // Bit positions inside the 4-bit flag vector
    localparam int FLAG_C = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    localparam int DATA_W = 8;
    localparam int FLAGS_W = 4;

endpackage

// File: rtl/alu_adder8.sv
// 8-bit ripple-carry adder shared by ADD (cin=0) and SUB (b inverted, cin=1).
// Latency: purely combinational.
// Backpressure: none.
module alu_adder8
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    logic [DATA_W:0] w_carry;

    // Ripple the carry bit by bit from cin up to the carry-out of bit 7
    always_comb begin
        sum        = '0;
        w_carry    = '0;
        w_carry[0] = cin;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_carry[DATA_W];
    // Signed overflow: carry into the sign bit differs from carry out of it
    assign ovf  = w_carry[DATA_W] ^ w_carry[DATA_W-1];

endmodule

// File: rtl/alu.sv
// 8-bit ALU (shift left, add, arithmetic shift right, subtract) with C/O/N/Z flags.
// Latency: one cycle, result and flags registered together in one 12-bit flop bank.
// Backpressure: none; a new operation is accepted on every non-reset edge.
module alu
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   alu_in_one,
    input  logic [DATA_W-1:0]   alu_in_two,
    input  logic                c12,
    input  logic                c13,
    output logic [DATA_W-1:0]   alu_result,
    output logic [FLAGS_W-1:0]  alu_flags
);

    alu_op_e                    w_op;
    logic                       w_is_sub;
    logic [DATA_W-1:0]          w_add_b;
    logic [DATA_W-1:0]          w_sum;
    logic                       w_cout;
    logic                       w_ovf;
    logic [DATA_W-1:0]          w_result;
    logic [FLAGS_W-1:0]         w_flags;
    logic [FLAGS_W+DATA_W-1:0]  r_out;

    assign w_op     = alu_op_e'({c13, c12});
    assign w_is_sub = (w_op == OP_SUB);
    // SUB reuses the adder as A + ~B + 1
    assign w_add_b  = w_is_sub ? ~alu_in_two : alu_in_two;

    alu_adder8 u_adder (
        .a    (alu_in_one),
        .b    (w_add_b),
        .cin  (w_is_sub),
        .sum  (w_sum),
        .cout (w_cout),
        .ovf  (w_ovf)
    );

    // Select result and C/O per opcode, then derive N/Z from the chosen result
    always_comb begin
        w_result = '0;
        w_flags  = '0;
        unique case (w_op)
            OP_SHIFTL: begin
                w_result         = {alu_in_one[DATA_W-2:0], 1'b0};
                w_flags[FLAG_C]  = alu_in_one[DATA_W-1];
                w_flags[FLAG_O]  = alu_in_one[DATA_W-1] ^ alu_in_one[DATA_W-2];
            end
            OP_SHIFTR: begin
                w_result         = {alu_in_one[DATA_W-1], alu_in_one[DATA_W-1:1]};
                w_flags[FLAG_C]  = alu_in_one[0];
                w_flags[FLAG_O]  = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                w_result         = w_sum;
                w_flags[FLAG_C]  = w_cout;
                w_flags[FLAG_O]  = w_ovf;
            end
        endcase
        w_flags[FLAG_N] = w_result[DATA_W-1];
        w_flags[FLAG_Z] = (w_result == '0);
    end

    // Single output register; reset clears result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= {w_flags, w_result};
        end
    end

    assign alu_result = r_out[DATA_W-1:0];
    assign alu_flags  = r_out[FLAGS_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU: directed corner cases plus random operations.
// Latency: expects each operation on the outputs one edge after it is presented.
// Backpressure: none; drives a new operation every cycle.
module tb_alu;

    logic       clk;
    logic       reset;
    logic [7:0] alu_in_one;
    logic [7:0] alu_in_two;
    logic       c12;
    logic       c13;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;

    int n_vectors;
    int n_miscompares;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .alu_in_one (alu_in_one),
        .alu_in_two (alu_in_two),
        .c12        (c12),
        .c13        (c13),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic on plain integers, flags from value ranges.
    // Returns {C,O,N,Z, result}.
    function automatic logic [11:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] op);
        int ua;
        int ub;
        int sa;
        int sb;
        int u;
        int s;
        int r;
        logic c;
        logic o;
        ua = a;
        ub = b;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        c = 1'b0;
        o = 1'b0;
        r = 0;
        case (op)
            2'd0: begin // shift left: doubling
                r = (ua * 2) % 256;
                c = (ua >= 128);
                s = sa * 2;
                o = (s > 127) || (s < -128);
            end
            2'd1: begin // add
                u = ua + ub;
                r = u % 256;
                c = (u > 255);
                s = sa + sb;
                o = (s > 127) || (s < -128);
            end
            2'd2: begin // arithmetic shift right: floor halving
                s = (sa < 0) ? -((-sa + 1) / 2) : sa / 2;
                r = (s + 256) % 256;
                c = (ua % 2) == 1;
                o = 1'b0;
            end
            default: begin // subtract
                u = ua + (255 - ub) + 1;
                r = u % 256;
                c = (u > 255);
                s = sa - sb;
                o = (s > 127) || (s < -128);
            end
        endcase
        ref_model = {c, o, (r >= 128), (r == 0), 8'(r)};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got flags=%b result=%h, expected flags=%b result=%h",
                     tag, got[11:8], got[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    // Present one operation, clock it, and check the registered outputs
    task automatic apply(input string tag, input logic rst, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] op);
        logic [11:0] exp;
        reset      = rst;
        alu_in_one = a;
        alu_in_two = b;
        {c13, c12} = op;
        exp = rst ? 12'h000 : ref_model(a, b, op);
        @(posedge clk);
        #1;
        check(tag, {alu_flags, alu_result}, exp);
    endtask

    task automatic check_fixed(input string tag, input logic [11:0] exp);
        check(tag, {alu_flags, alu_result}, exp);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        reset         = 1'b1;
        alu_in_one    = 8'h00;
        alu_in_two    = 8'h00;
        c12           = 1'b0;
        c13           = 1'b0;

        // Reset state, with junk on the inputs
        apply("reset_state", 1'b1, 8'hA5, 8'h3C, 2'b01);

        // Directed cases with hand-derived expectations {C,O,N,Z, R}
        apply("shiftl_5a", 1'b0, 8'h5A, 8'h00, 2'b00);
        check_fixed("shiftl_5a_const", {4'b0110, 8'hB4});
        apply("add_120_10", 1'b0, 8'd120, 8'd10, 2'b01);
        check_fixed("add_120_10_const", {4'b0110, 8'h82});
        apply("add_ff_01", 1'b0, 8'hFF, 8'h01, 2'b01);
        check_fixed("add_ff_01_const", {4'b1001, 8'h00});
        apply("shiftr_81", 1'b0, 8'h81, 8'h00, 2'b10);
        check_fixed("shiftr_81_const", {4'b1010, 8'hC0});
        apply("shiftr_01", 1'b0, 8'h01, 8'h00, 2'b10);
        check_fixed("shiftr_01_const", {4'b1001, 8'h00});
        apply("sub_20_50", 1'b0, 8'd20, 8'd50, 2'b11);
        check_fixed("sub_20_50_const", {4'b0010, 8'hE2});
        apply("sub_80_01", 1'b0, 8'h80, 8'h01, 2'b11);
        check_fixed("sub_80_01_const", {4'b1100, 8'h7F});
        apply("sub_equal", 1'b0, 8'h37, 8'h37, 2'b11);
        check_fixed("sub_equal_const", {4'b1001, 8'h00});

        // Mid-stream reset discards the op; next edge registers it
        apply("rst_mid", 1'b1, 8'hFF, 8'h01, 2'b01);
        check_fixed("rst_mid_const", 12'h000);
        apply("rst_release", 1'b0, 8'hFF, 8'h01, 2'b01);
        check_fixed("rst_release_const", {4'b1001, 8'h00});

        // Back-to-back ops, one per cycle, each visible exactly one edge later
        apply("b2b_0", 1'b0, 8'h40, 8'h00, 2'b00);
        apply("b2b_1", 1'b0, 8'h7F, 8'h01, 2'b01);
        apply("b2b_2", 1'b0, 8'hFE, 8'h00, 2'b10);
        apply("b2b_3", 1'b0, 8'h00, 8'h01, 2'b11);
        // Output holds until the next edge even when inputs move mid-cycle
        alu_in_one = 8'h12;
        alu_in_two = 8'h34;
        {c13, c12} = 2'b01;
        #3;
        check_fixed("b2b_hold", {4'b0010, 8'hFF});

        // Random operations with occasional reset
        for (int i = 0; i < 400; i++) begin
            apply("random", ($urandom_range(0, 19) == 0),
                  8'($urandom), 8'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
